// File: rtl/lbm_ctrl_pkg.sv
// Shared types and constants for the LBM chunk control path.
package lbm_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSTART,
        COMPUTE,
        STORE_RD,
        STORE_WR,
        NEXT,
        FINISH
    } seq_state_e;

    // Cycles between presenting a BRAM address and the read data being valid.
    localparam int unsigned BRAM_RD_LAT = 1;

    // BRAM ownership phase; bit 0 routes BRAM to DDR/cache, bit 1 to the solver.
    typedef logic [1:0] phase_t;

    localparam phase_t PHASE_NONE    = 2'b00;
    localparam phase_t PHASE_XFER    = 2'b01;
    localparam phase_t PHASE_COMPUTE = 2'b10;

    // Ownership phase implied by a sequencer state.
    function automatic phase_t phase_of(input seq_state_e s);
        phase_t p;
        p = PHASE_NONE;
        case (s)
            LOAD, STORE_RD, STORE_WR: p = PHASE_XFER;
            CSTART, COMPUTE:          p = PHASE_COMPUTE;
            default:                  p = PHASE_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/chunk_addr_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; incrementing
// at the terminal value returns the count to zero.
module chunk_addr_counter #(
    parameter int unsigned W    = 12,
    parameter int unsigned LAST = 4095
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear dominates, increment restarts from zero after LAST.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == LAST_V) ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST_V);

endmodule

// File: rtl/chunk_phase_sequencer.sv
// Per-chunk BRAM ownership sequencer: LOAD -> COMPUTE -> STORE for each chunk.
module chunk_phase_sequencer
    import lbm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned CHUNK_WORDS = 4096,
    parameter int unsigned NUM_CHUNKS  = 16,
    parameter int unsigned IDX_W       = 8
) (
    input  logic              m00_axis_aclk,
    input  logic              m00_axis_aresetn,
    input  logic              start,
    input  logic              abort,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              compute_start,
    input  logic              compute_done,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              chunk_transfer_ready,
    output logic              chunk_compute_ready,
    output logic              xfer_write,
    output logic [ADDR_W-1:0] DDR_addr,
    output logic [IDX_W-1:0]  chunk_idx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned RD_CNT_W = (BRAM_RD_LAT > 1) ? $clog2(BRAM_RD_LAT) : 1;

    seq_state_e state_q, state_d;

    logic addr_clr, addr_inc, addr_tc;
    logic idx_clr, idx_inc, idx_tc;

    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic                rd_last;

    phase_t phase_d;
    logic   ld_ready_q, ld_ready_d;
    logic   cstart_q, cstart_d;
    logic   wb_valid_q, wb_valid_d;
    logic   xfer_rdy_q, xfer_rdy_d;
    logic   comp_rdy_q, comp_rdy_d;
    logic   xfer_write_q, xfer_write_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    assign rd_last = (rd_cnt_q == RD_CNT_W'(BRAM_RD_LAT - 1));

    // Next state and counter control; abort overrides every state.
    always_comb begin
        state_d  = state_q;
        addr_clr = 1'b0;
        addr_inc = 1'b0;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        rd_cnt_d = '0;
        if (abort) begin
            state_d  = IDLE;
            addr_clr = 1'b1;
            idx_clr  = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = LOAD;
                        addr_clr = 1'b1;
                        idx_clr  = 1'b1;
                    end
                end
                LOAD: begin
                    // ld_ready is registered high for the whole LOAD state.
                    if (ld_valid) begin
                        addr_inc = 1'b1;
                        if (addr_tc) begin
                            state_d = CSTART;
                        end
                    end
                end
                CSTART: begin
                    state_d = COMPUTE;
                end
                COMPUTE: begin
                    if (compute_done) begin
                        state_d = STORE_RD;
                    end
                end
                STORE_RD: begin
                    if (rd_last) begin
                        state_d = STORE_WR;
                    end else begin
                        rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
                    end
                end
                STORE_WR: begin
                    if (wb_ready) begin
                        addr_inc = 1'b1;
                        state_d  = addr_tc ? NEXT : STORE_RD;
                    end
                end
                NEXT: begin
                    if (idx_tc) begin
                        state_d = FINISH;
                    end else begin
                        idx_inc = 1'b1;
                        state_d = LOAD;
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        phase_d      = phase_of(state_d);
        xfer_rdy_d   = phase_d[0];
        comp_rdy_d   = phase_d[1];
        ld_ready_d   = (state_d == LOAD);
        xfer_write_d = (state_d == LOAD);
        cstart_d     = (state_d == CSTART);
        wb_valid_d   = (state_d == STORE_WR);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
    end

    // State, read-latency counter and registered outputs.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q      <= IDLE;
            rd_cnt_q     <= '0;
            ld_ready_q   <= 1'b0;
            cstart_q     <= 1'b0;
            wb_valid_q   <= 1'b0;
            xfer_rdy_q   <= 1'b0;
            comp_rdy_q   <= 1'b0;
            xfer_write_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            ld_ready_q   <= ld_ready_d;
            cstart_q     <= cstart_d;
            wb_valid_q   <= wb_valid_d;
            xfer_rdy_q   <= xfer_rdy_d;
            comp_rdy_q   <= comp_rdy_d;
            xfer_write_q <= xfer_write_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    chunk_addr_counter #(
        .W    (ADDR_W),
        .LAST (CHUNK_WORDS - 1)
    ) u_addr_cnt (
        .clk_i   (m00_axis_aclk),
        .rst_ni  (m00_axis_aresetn),
        .clear_i (addr_clr),
        .inc_i   (addr_inc),
        .count_o (DDR_addr),
        .tc_o    (addr_tc)
    );

    chunk_addr_counter #(
        .W    (IDX_W),
        .LAST (NUM_CHUNKS - 1)
    ) u_idx_cnt (
        .clk_i   (m00_axis_aclk),
        .rst_ni  (m00_axis_aresetn),
        .clear_i (idx_clr),
        .inc_i   (idx_inc),
        .count_o (chunk_idx),
        .tc_o    (idx_tc)
    );

    assign ld_ready             = ld_ready_q;
    assign compute_start        = cstart_q;
    assign wb_valid             = wb_valid_q;
    assign chunk_transfer_ready = xfer_rdy_q;
    assign chunk_compute_ready  = comp_rdy_q;
    assign xfer_write           = xfer_write_q;
    assign busy                 = busy_q;
    assign done                 = done_q;

endmodule

// File: tb/tb_chunk_phase_sequencer.sv
// Self-checking bench for chunk_phase_sequencer against a behavioural model.
module tb_chunk_phase_sequencer;

    localparam int unsigned AW = 12;
    localparam int unsigned CW = 4;
    localparam int unsigned NC = 2;
    localparam int unsigned IW = 8;

    // Model phases (independent of the RTL encoding).
    localparam int M_IDLE    = 0;
    localparam int M_LOAD    = 1;
    localparam int M_CSTART  = 2;
    localparam int M_COMPUTE = 3;
    localparam int M_SRD     = 4;
    localparam int M_SWR     = 5;
    localparam int M_NEXT    = 6;
    localparam int M_FIN     = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort, ld_valid, compute_done, wb_ready;
    logic          ld_ready, compute_start, wb_valid;
    logic          chunk_transfer_ready, chunk_compute_ready, xfer_write;
    logic [AW-1:0] DDR_addr;
    logic [IW-1:0] chunk_idx;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int m_st, m_addr, m_idx;

    always #5 clk = ~clk;

    chunk_phase_sequencer #(
        .ADDR_W      (AW),
        .CHUNK_WORDS (CW),
        .NUM_CHUNKS  (NC),
        .IDX_W       (IW)
    ) dut (
        .m00_axis_aclk        (clk),
        .m00_axis_aresetn     (rst_n),
        .start                (start),
        .abort                (abort),
        .ld_valid             (ld_valid),
        .ld_ready             (ld_ready),
        .compute_start        (compute_start),
        .compute_done         (compute_done),
        .wb_valid             (wb_valid),
        .wb_ready             (wb_ready),
        .chunk_transfer_ready (chunk_transfer_ready),
        .chunk_compute_ready  (chunk_compute_ready),
        .xfer_write           (xfer_write),
        .DDR_addr             (DDR_addr),
        .chunk_idx            (chunk_idx),
        .busy                 (busy),
        .done                 (done)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = M_IDLE;
        m_addr = 0;
        m_idx  = 0;
    endtask

    // One clock of the specified behaviour, using the inputs present at the edge.
    task automatic model_step();
        if (abort) begin
            model_reset();
        end else begin
            case (m_st)
                M_IDLE: if (start) begin m_st = M_LOAD; m_addr = 0; m_idx = 0; end
                M_LOAD: if (ld_valid) begin
                    if (m_addr == CW - 1) begin m_addr = 0; m_st = M_CSTART; end
                    else m_addr++;
                end
                M_CSTART:  m_st = M_COMPUTE;
                M_COMPUTE: if (compute_done) m_st = M_SRD;
                M_SRD:     m_st = M_SWR;
                M_SWR: if (wb_ready) begin
                    if (m_addr == CW - 1) begin m_addr = 0; m_st = M_NEXT; end
                    else begin m_addr++; m_st = M_SRD; end
                end
                M_NEXT: if (m_idx == NC - 1) m_st = M_FIN;
                        else begin m_idx++; m_st = M_LOAD; end
                M_FIN: m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    endtask

    task automatic compare_all();
        bit xfer, comp;
        xfer = (m_st == M_LOAD) || (m_st == M_SRD) || (m_st == M_SWR);
        comp = (m_st == M_CSTART) || (m_st == M_COMPUTE);
        check_val("ld_ready",      ld_ready,             m_st == M_LOAD);
        check_val("xfer_write",    xfer_write,           m_st == M_LOAD);
        check_val("compute_start", compute_start,        m_st == M_CSTART);
        check_val("wb_valid",      wb_valid,             m_st == M_SWR);
        check_val("xfer_ready",    chunk_transfer_ready, xfer);
        check_val("comp_ready",    chunk_compute_ready,  comp);
        check_val("excl",          chunk_transfer_ready & chunk_compute_ready, 0);
        check_val("busy",          busy,                 m_st != M_IDLE);
        check_val("done",          done,                 m_st == M_FIN);
        check_val("DDR_addr",      DDR_addr,             m_addr);
        check_val("chunk_idx",     chunk_idx,            m_idx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic wait_for(input int target, input int budget, input string tag, output int n);
        n = 0;
        while (m_st != target && n < budget) begin
            tick();
            n++;
        end
        check_val(tag, m_st, target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; ld_valid = 1'b0; compute_done = 1'b0; wb_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
        tick(); tick();

        // Streaming load: address steps every cycle, then one CSTART cycle.
        ld_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_for(M_CSTART, 10, "reach_cstart", n);
        check_val("load_stream_cycles", n, 4);
        ld_valid = 1'b0;

        // Compute held off for 50 cycles.
        repeat (50) tick();
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        check_val("store_rd_entry", chunk_transfer_ready, 1);

        // Store stall at address 2.
        wb_ready = 1'b1;
        n = 0;
        while (!(m_st == M_SWR && m_addr == 2) && n < 20) begin tick(); n++; end
        wb_ready = 1'b0;
        repeat (5) tick();
        check_val("stall_wb_valid", wb_valid, 1);
        check_val("stall_addr", DDR_addr, 2);
        wb_ready = 1'b1;
        wait_for(M_NEXT, 10, "reach_next", n);
        wb_ready = 1'b0;
        wait_for(M_LOAD, 5, "reach_load1", n);

        // Chunk 1 load with alternating valid: 4 words in 8 cycles.
        n = 0;
        while (ld_ready === 1'b1 && n < 20) begin
            ld_valid = n[0];
            tick();
            n++;
        end
        check_val("load_bp_cycles", n, 8);
        ld_valid = 1'b0;

        // Start during a run is ignored; finish the run.
        start = 1'b1;
        tick();
        start = 1'b0;
        done_cnt = 0;
        compute_done = 1'b1; wb_ready = 1'b1;
        wait_for(M_FIN, 60, "reach_finish", n);
        tick();
        tick();
        check_val("done_pulses", done_cnt, 1);
        check_val("idx_hold", chunk_idx, NC - 1);

        // Abort in COMPUTE of chunk 1.
        start = 1'b1;
        tick();
        start = 1'b0;
        ld_valid = 1'b1;
        n = 0;
        while (!(m_st == M_COMPUTE && m_idx == 1) && n < 80) begin tick(); n++; end
        check_val("reach_compute1", m_idx, 1);
        done_cnt = 0;
        compute_done = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        repeat (3) tick();
        check_val("abort_no_done", done_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("restart_addr", DDR_addr, 0);
        check_val("restart_idx", chunk_idx, 0);

        // Asynchronous reset while waiting in STORE_WR.
        compute_done = 1'b1; wb_ready = 1'b0;
        wait_for(M_SWR, 30, "reach_swr", n);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        compute_done = 1'b0; ld_valid = 1'b0;
        tick();

        // abort with start in IDLE stays idle; start beats compute_done in IDLE.
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check_val("abort_start_idle", busy, 0);
        start = 1'b1; compute_done = 1'b1;
        tick();
        start = 1'b0; compute_done = 1'b0;
        check_val("start_wins", ld_ready, 1);
        tick();

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            start        = ($urandom_range(15) == 0);
            abort        = ($urandom_range(149) == 0);
            ld_valid     = $urandom_range(1);
            compute_done = ($urandom_range(5) == 0);
            wb_ready     = ($urandom_range(9) < 6);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_phase_sequencer.md
Name: chunk_phase_sequencer

Overview:
- Sequences the per-chunk BRAM ownership handshake: LOAD (DDR→BRAM), COMPUTE (LBM solver owns BRAM), STORE (BRAM→DDR), then repeats for NUM_CHUNKS chunks.
- Drives chunk_transfer_ready / chunk_compute_ready and DDR_addr into the BRAM toggle mux.
- Handshakes with the DMA load stream, the LBM solver and the writeback stream.

Parameters:
ADDR_W, 12, BRAM word address width (matches the 12-bit distribution addresses)
CHUNK_WORDS, 4096, words per chunk; legal range 2..2**ADDR_W
NUM_CHUNKS, 16, chunks per run; legal range ≥1
IDX_W, 8, chunk index width; NUM_CHUNKS ≤ 2**IDX_W

Ports:
m00_axis_aclk  in  1  clock
m00_axis_aresetn  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a run from IDLE
abort  in  1  level; forces return to IDLE
ld_valid  in  1  DMA load word valid
ld_ready  out  1  sequencer accepts load word
compute_start  out  1  one-cycle pulse to LBM solver
compute_done  in  1  solver finished current chunk (pulse or level)
wb_valid  out  1  BRAM read data valid for writeback
wb_ready  in  1  writeback sink accepts word
chunk_transfer_ready  out  1  BRAM routed to DDR/cache side
chunk_compute_ready  out  1  BRAM routed to LBM solver
xfer_write  out  1  1 = transfer is a BRAM write (LOAD); 0 = read (STORE)
DDR_addr  out  ADDR_W  BRAM word address during transfer
chunk_idx  out  IDX_W  current chunk number
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion

Behaviour:
- All outputs registered (Moore). Reset values: every output 0; state IDLE.
- IDLE: start=1 → LOAD. DDR_addr=0, chunk_idx=0.
- LOAD: chunk_transfer_ready=1, xfer_write=1, ld_ready=1.
  - Each ld_valid&&ld_ready cycle: DDR_addr+1.
  - Handshake at DDR_addr==CHUNK_WORDS-1 → DDR_addr←0, go to CSTART.
  - ld_valid low: address holds.
- CSTART: exactly one cycle with compute_start=1 and chunk_compute_ready=1, then COMPUTE.
- COMPUTE: chunk_compute_ready=1 until compute_done=1 is sampled, then STORE_RD.
- STORE_RD: chunk_transfer_ready=1, xfer_write=0, DDR_addr presented for one cycle (BRAM read latency 1), then STORE_WR.
- STORE_WR: chunk_transfer_ready=1, wb_valid=1, held until wb_ready=1.
  - On handshake: if DDR_addr==CHUNK_WORDS-1 → DDR_addr←0, go to NEXT.
  - Otherwise DDR_addr+1, go to STORE_RD.
  - Throughput is 1 word per 2 cycles minimum.
- NEXT: if chunk_idx==NUM_CHUNKS-1 → FINISH; else chunk_idx+1, go to LOAD.
- FINISH: done=1 for one cycle → IDLE. chunk_idx holds its last value until the next start.
- Invariant: chunk_transfer_ready and chunk_compute_ready are never both 1. Both are 0 in IDLE, NEXT and FINISH.
- ld_ready=0 and wb_valid=0 outside their states. ld_valid outside LOAD is ignored.
- start while busy: ignored. compute_done outside COMPUTE: ignored, not latched.
- start and compute_done in the same cycle from IDLE: start wins, compute_done dropped.
- abort:
  - Highest priority after reset; next cycle state=IDLE, all outputs 0, counters cleared, no done pulse.
  - abort together with start in IDLE: stay in IDLE.
- Reset mid-operation: immediate return to reset values, no done.
- Counters never wrap past their terminal value. DDR_addr compares at CHUNK_WORDS-1, so CHUNK_WORDS=2**ADDR_W is legal.

Decomposition:
- Shared package (lbm_ctrl_pkg):
  - state enum {IDLE, LOAD, CSTART, COMPUTE, STORE_RD, STORE_WR, NEXT, FINISH}
  - localparam for BRAM read latency (1)
  - phase encoding constants reused by the toggle mux and the top level
- One sub-module: chunk_addr_counter (ADDR_W). Ports: clear, inc, terminal-count flag. Used for DDR_addr; a second instance (width IDX_W) serves chunk_idx.

Test Plan (CHUNK_WORDS=4, NUM_CHUNKS=2 unless stated):
- Reset then idle: all outputs 0; start with ld_valid=1 continuous → DDR_addr 0,1,2,3 on consecutive cycles, then CSTART. compute_start high exactly 1 cycle; transfer_ready drops the same cycle compute_ready rises.
- Load backpressure: ld_valid toggled 1,0,1,0… → DDR_addr advances only on valid cycles; 4 accepted words take 8 cycles.
- Compute hold: compute_done withheld 50 cycles → chunk_compute_ready stays 1, DDR_addr 0; compute_done pulse → STORE_RD next cycle.
- Store stall: wb_ready held low 5 cycles at DDR_addr=2 → wb_valid stays 1, DDR_addr stays 2; release → 3 then NEXT.
- Full run: two chunks with wb_ready=1 → chunk_idx 0→1, one done pulse, busy falls the cycle after done; a start during the run is ignored.
- Abort in COMPUTE of chunk 1 (and a separate case with async reset asserted in STORE_WR) → IDLE next cycle, all outputs 0, no done; a subsequent start restarts at chunk_idx=0, DDR_addr=0.
